// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode/ALU encodings and the control bundle
// carried from ID/EX through EX/MEM and MEM/WB.
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RT,
        DST_RD
    } dst_sel_e;

    // Opcodes whose rt field is a source operand (others treat rt as a destination or ignore it).
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with x0 hardwired to zero, write-through
// bypass on the read ports and synchronous clear.
module reg_file #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic [1:0][4:0]      raddr_i,
    output logic [1:0][XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            // Same-cycle write of the addressed register is forwarded so decode sees it now.
            always_comb begin
                if (raddr_i[gi] == 5'd0) begin
                    rdata_o[gi] = '0;
                end else if (we_i && (waddr_i == raddr_i[gi])) begin
                    rdata_o[gi] = wdata_i;
                end else begin
                    rdata_o[gi] = regs_q[raddr_i[gi]];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_stage.sv
// Instruction decode, load-use hazard detection and the ID/EX pipeline
// register; also hosts the register file and its write-back port.
module id_stage
    import pipeline_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            instr_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_dst,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_alu_src,
    output logic            ex_branch,
    output logic [1:0]      ex_alu_op,
    output logic [5:0]      ex_funct,
    output logic            ex_illegal
);

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  funct;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign imm    = instruction[15:0];
    assign funct  = instruction[5:0];

    // Register file
    logic [1:0][4:0]      rf_raddr;
    logic [1:0][XLEN-1:0] rf_rdata;

    assign rf_raddr[0] = rs;
    assign rf_raddr[1] = rt;

    reg_file #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_reg_file (
        .clk_i   (CLK),
        .srst_i  (reset),
        .we_i    (wb_we),
        .waddr_i (wb_addr),
        .wdata_i (wb_data),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata)
    );

    // Decode
    ctrl_t    dec_ctrl;
    logic     dec_illegal;
    dst_sel_e dec_dst_sel;
    logic [4:0] dec_dst;

    always_comb begin
        dec_ctrl    = CTRL_NOP;
        dec_illegal = 1'b0;
        dec_dst_sel = DST_NONE;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_OP_FUNCT;
                dec_dst_sel        = DST_RD;
            end
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.alu_op     = ALU_OP_ADD;
                dec_dst_sel         = DST_RT;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_OP_SUB;
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_OP_ADD;
                dec_dst_sel        = DST_RT;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (dec_dst_sel)
            DST_RT:  dec_dst = rt;
            DST_RD:  dec_dst = rd;
            default: dec_dst = 5'd0;
        endcase
    end

    // ID/EX state
    logic            ex_valid_q,   ex_valid_d;
    ctrl_t           ex_ctrl_q,    ex_ctrl_d;
    logic            ex_illegal_q, ex_illegal_d;
    logic [XLEN-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [XLEN-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [XLEN-1:0] ex_imm_q,     ex_imm_d;
    logic [4:0]      ex_rs_q,      ex_rs_d;
    logic [4:0]      ex_rt_q,      ex_rt_d;
    logic [4:0]      ex_dst_q,     ex_dst_d;
    logic [5:0]      ex_funct_q,   ex_funct_d;

    // A load in EX cannot forward in time for a dependent instruction in decode.
    logic load_in_ex;
    logic dep_hit;

    assign load_in_ex = ex_valid_q && ex_ctrl_q.mem_read && (ex_dst_q != 5'd0);
    assign dep_hit    = (ex_dst_q == rs) || (uses_rt(opcode) && (ex_dst_q == rt));
    assign stall      = instr_valid && !flush && load_in_ex && dep_hit;

    logic load_id_ex;
    assign load_id_ex = instr_valid && !flush && !stall;

    always_comb begin
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = CTRL_NOP;
        ex_illegal_d = 1'b0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_dst_d     = '0;
        ex_funct_d   = '0;
        if (load_id_ex) begin
            ex_valid_d   = 1'b1;
            ex_ctrl_d    = dec_ctrl;
            ex_illegal_d = dec_illegal;
            ex_rs_data_d = rf_rdata[0];
            ex_rt_data_d = rf_rdata[1];
            ex_imm_d     = {{(XLEN-16){imm[15]}}, imm};
            ex_rs_d      = rs;
            ex_rt_d      = rt;
            ex_dst_d     = dec_dst;
            ex_funct_d   = funct;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= CTRL_NOP;
            ex_illegal_q <= 1'b0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_dst_q     <= '0;
            ex_funct_q   <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_illegal_q <= ex_illegal_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_dst_q     <= ex_dst_d;
            ex_funct_q   <= ex_funct_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_dst        = ex_dst_q;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_funct      = ex_funct_q;
    assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Randomized scoreboard bench for id_stage: a behavioural model predicts the
// ID/EX contents each cycle and the combinational stall.
module tb_id_stage;

    logic        CLK;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic        ex_illegal;

    id_stage #(.NREG(32), .XLEN(32)) dut (
        .CLK(CLK), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
        .ex_funct(ex_funct), .ex_illegal(ex_illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        illegal;
    } idex_t;

    idex_t       exp_q[$];
    idex_t       model_ex;
    logic [31:0] model_regs [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        last_stall = 1'b0;

    function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        idex_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.rs_data = a;
        e.rt_data = b;
        e.imm     = {{16{ins[15]}}, ins[15:0]};
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.funct   = ins[5:0];
        case (ins[31:26])
            6'h00: begin e.reg_write = 1; e.alu_op = 2'b10; e.dst = ins[15:11]; end
            6'h23: begin e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; e.dst = ins[20:16]; end
            6'h2B: begin e.mem_write = 1; e.alu_src = 1; end
            6'h04: begin e.branch = 1; e.alu_op = 2'b01; end
            6'h08: begin e.reg_write = 1; e.alu_src = 1; e.dst = ins[20:16]; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_we && wb_addr == idx) return wb_data;
        return model_regs[idx];
    endfunction

    function automatic logic model_stall();
        logic [5:0] op;
        logic       rt_src;
        op     = instruction[31:26];
        rt_src = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        if (!instr_valid || flush) return 1'b0;
        if (!model_ex.valid || !model_ex.mem_read || model_ex.dst == 0) return 1'b0;
        return (model_ex.dst == instruction[25:21]) || (rt_src && model_ex.dst == instruction[20:16]);
    endfunction

    // One clock: drive inputs, check stall, predict the next ID/EX contents.
    task automatic step(input logic rst, input logic [31:0] ins, input logic iv, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic  exp_stall;
        idex_t nxt;
        reset = rst; instruction = ins; instr_valid = iv; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        exp_stall = model_stall();
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL stall cycle %0d: got %b expected %b", cyc, stall, exp_stall);
        end
        if (rst || fl || exp_stall || !iv) nxt = '0;
        else nxt = model_decode(ins, model_read(ins[25:21]), model_read(ins[20:16]));
        exp_q.push_back(nxt);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
        end else if (we && wa != 0) begin
            model_regs[wa] = wd;
        end
        model_ex   = nxt;
        last_stall = exp_stall;
        $display("cycle %0d: rst=%b ins=%h iv=%b fl=%b we=%b wa=%0d wd=%h stall=%b", cyc, rst, ins, iv, fl, we, wa, wd, exp_stall);
        @(posedge CLK);
        #2;
    endtask

    // Monitor: compares the ID/EX contents after each edge against the scoreboard.
    initial begin
        idex_t act, exp_v;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = '{ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst,
                        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                        ex_branch, ex_alu_op, ex_funct, ex_illegal};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL idex cycle %0d: got %h expected %h", cyc, act, exp_v);
                end
                cyc++;
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        logic [15:0] lo;
        model_ex = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        reset = 1; instruction = 0; instr_valid = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        @(posedge CLK);
        #2;

        // Reset state, then addi sign-extension
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, itype(6'h08, 5'd0, 5'd5, 16'hFFFC), 1, 0, 0, 0, 0);
        // Write-through bypass
        step(0, rtype(5'd3, 5'd0, 5'd4), 1, 0, 1, 5'd3, 32'h1234);
        // Load-use on rs: one bubble, then the add proceeds
        step(0, itype(6'h23, 5'd1, 5'd7, 16'h0010), 1, 0, 0, 0, 0);
        step(0, rtype(5'd7, 5'd2, 5'd8), 1, 0, 0, 0, 0);
        step(0, rtype(5'd7, 5'd2, 5'd8), 1, 0, 0, 0, 0);
        // Load followed by addi writing the same rt: no stall
        step(0, itype(6'h23, 5'd1, 5'd7, 16'h0010), 1, 0, 0, 0, 0);
        step(0, itype(6'h08, 5'd2, 5'd7, 16'h0001), 1, 0, 0, 0, 0);
        // Flush together with a hazard
        step(0, itype(6'h23, 5'd1, 5'd7, 16'h0010), 1, 0, 0, 0, 0);
        step(0, rtype(5'd7, 5'd2, 5'd8), 1, 1, 0, 0, 0);
        // Illegal opcode, and x0 stays zero
        step(0, {6'h3F, 26'h155_5555}, 1, 0, 1, 5'd0, 32'hFFFF);
        step(0, rtype(5'd0, 5'd0, 5'd1), 1, 0, 0, 0, 0);
        // Reset during a stall with a write pending
        step(0, itype(6'h23, 5'd1, 5'd9, 16'h0004), 1, 0, 0, 0, 0);
        step(1, rtype(5'd9, 5'd10, 5'd2), 1, 0, 1, 5'd10, 32'hDEAD_BEEF);
        step(0, rtype(5'd10, 5'd9, 5'd2), 1, 0, 0, 0, 0);

        // Randomized traffic, fetch holding the instruction while stalled
        ins = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 5))
                    0: op = 6'h00;
                    1: op = 6'h23;
                    2: op = 6'h2B;
                    3: op = 6'h04;
                    4: op = 6'h08;
                    default: op = 6'($urandom);
                endcase
                lo = 16'($urandom);
                lo[15:11] = 5'($urandom_range(0, 7));
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), lo};
            end
            step(($urandom_range(0, 99) == 0), ins, last_stall || ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage plus ID/EX pipeline register for the 32-bit MIPS-style pipeline. Consumes the instruction word produced by the fetch stage, reads the 32×32 register file, sign-extends the 16-bit immediate, generates control, detects load-use hazards, and registers everything for the execute stage. It also accepts the write-back port into the register file.

## Interface
Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired to zero)
- XLEN, 32, datapath width

Ports:
- CLK  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  32  instruction from fetch
- instr_valid  in  1  instruction is real (0 = bubble)
- flush  in  1  squash the instruction in decode (taken branch)
- wb_we  in  1  register-file write enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- stall  out  1  combinational; fetch must hold PC and instruction
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data, ex_rt_data  out  32  operand values
- ex_imm  out  32  sign-extended instruction[15:0]
- ex_rs, ex_rt, ex_dst  out  5  source indices, destination index
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1  control
- ex_alu_op  out  2  00 add, 01 sub, 10 use funct
- ex_funct  out  6  instruction[5:0]
- ex_illegal  out  1  unrecognised opcode

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0].
- Decode:
  - R-type 0x00: reg_write, alu_op=10, dst=rd.
  - lw 0x23: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00, dst=rt.
  - sw 0x2B: mem_write, alu_src, alu_op=00.
  - beq 0x04: branch, alu_op=01.
  - addi 0x08: reg_write, alu_src, alu_op=00, dst=rt.
  - Any other opcode: all control 0, illegal=1.
- Instructions that use rt as a source: R-type, sw, beq.
- Register file:
  - Two async read ports, one sync write port.
  - Writes to index 0 are ignored; index 0 always reads 0.
  - Same-cycle write/read of the same nonzero index returns wb_data (write-through bypass).
- Load-use hazard: stall=1 when all of the following hold:
  - instr_valid=1,
  - ex_valid=1 and ex_mem_read=1,
  - ex_dst≠0,
  - ex_dst==rs, or (ex_dst==rt and the instruction uses rt).
- ID/EX update each cycle, in priority order:
  1. reset → bubble.
  2. flush → bubble.
  3. stall → bubble (the decode instruction is held by fetch and re-decoded next cycle).
  4. instr_valid=0 → bubble.
  5. Otherwise load the decoded instruction with ex_valid=1.
- Bubble: ex_valid=0, every control bit 0, ex_illegal=0, data/index fields 0.
- stall is forced to 0 when flush=1.

## Timing
- Decode→ID/EX latency: 1 cycle; an instruction presented in cycle n appears on the ex_* outputs after edge n+1.
- stall is combinational from instruction and the current ID/EX contents, and is valid in the same cycle.
- A load followed immediately by a dependent instruction costs exactly one bubble. The second decode attempt sees ex_mem_read=0 and proceeds.
- A register-file write at edge n is visible to reads in cycle n via the bypass, and from the array afterwards.
- Reset values:
  - All ex_* outputs 0.
  - stall is 0 when ID/EX is empty.
  - All registers read 0.
- Reset mid-stall: the bubble is loaded and no state is retained.
- Reset with wb_we=1 in the same cycle: the write is dropped.

## Structure
- Shared package (pipeline_pkg):
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU_OP_ADD/SUB/FUNCT encodings;
  - a control-bundle typedef reused by the EX/MEM and MEM/WB registers.
- One sub-module: reg_file (2R1W, bypass, x0 hardwired, synchronous reset clear).
- Decode and hazard logic live in id_stage itself.

## Test plan
- Reset, then decode addi with rs=0, rt=5, imm=0xFFFC → ex_imm=0xFFFFFFFC, ex_dst=5, ex_reg_write=1, ex_alu_src=1, ex_alu_op=00, ex_valid=1.
- wb write r3=0x1234 while decoding `add rd=4, rs=3, rt=0` in the same cycle → ex_rs_data=0x1234 (bypass), ex_rt_data=0.
- lw r7 followed by `add rs=7` → stall=1 for one cycle, bubble in ID/EX, then the add enters with ex_valid=1. lw r7 followed by `addi rt=7` (rt not a source) → no stall.
- flush=1 together with a hazard → stall=0, ID/EX becomes a bubble.
- Opcode 0x3F → ex_illegal=1, all control 0, ex_valid=1. Write to r0 with 0xFFFF, then read r0 → 0.
- Assert reset during a stall while wb_we=1 → all ex_* outputs 0 next cycle, and the target register still reads 0.
